// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO, 2^ADDR_W x DATA_W, registered read, occupancy, ack/err pulses.
// Ports: clk, reset (sync, active-high) | wr_en, din -> write side | rd_en -> dout (1-cycle latency)
//        full, empty, data_count: status decoded from occupancy | wr_ack/wr_err, rd_ack/rd_err: previous-cycle outcome
//        almost_full, almost_empty: only when SYNC_FIFO_ALMOST_FLAGS_EN is defined (threshold ALMOST_TH)
module sync_fifo_param #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 3,
  parameter int ALMOST_TH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   data_count,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);
  localparam int DEPTH = 1 << ADDR_W;
  if (ALMOST_TH < 1 || ALMOST_TH > DEPTH - 1) begin : g_bad_almost_th
    $error("sync_fifo_param: ALMOST_TH out of range");
  end
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;
  logic              wr_acc, rd_acc;
  logic [DEPTH-1:0]  wr_sel;
  assign full   = cnt_q == (ADDR_W+1)'(DEPTH);
  assign empty  = cnt_q == '0;
  // a full FIFO still takes a write when a read frees the slot on the same edge
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);
  assign wr_sel = {{(DEPTH-1){1'b0}}, wr_acc} << wr_ptr_q;
  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    dout_d   = rd_acc ? mem_q[rd_ptr_q] : dout_q;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (wr_sel[i]) mem_q[i] <= din;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      wr_ack_q <= wr_acc;
      wr_err_q <= wr_en & ~wr_acc;
      rd_ack_q <= rd_acc;
      rd_err_q <= rd_en & ~rd_acc;
    end
  end
  assign dout       = dout_q;
  assign data_count = cnt_q;
  assign wr_ack     = wr_ack_q;
  assign wr_err     = wr_err_q;
  assign rd_ack     = rd_ack_q;
  assign rd_err     = rd_err_q;
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
  assign almost_full  = cnt_q >= (ADDR_W+1)'(DEPTH - ALMOST_TH);
  assign almost_empty = cnt_q <= (ADDR_W+1)'(ALMOST_TH);
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: randomized and directed bench for sync_fifo_param against a queue-based model.
module tb_sync_fifo_param;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam int TH     = 2;
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic [DATA_W-1:0] dout;
  logic              full, empty, wr_ack, wr_err, rd_ack, rd_err;
  logic [ADDR_W:0]   data_count;
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
  logic              almost_full, almost_empty;
`endif
  int                n_checks = 0;
  int                n_fail = 0;
  logic [DATA_W-1:0] q [$];
  logic [DATA_W-1:0] m_dout = '0;
  logic              m_wa = 1'b0, m_we = 1'b0, m_ra = 1'b0, m_re = 1'b0;
  always #5 clk = ~clk;
  sync_fifo_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ALMOST_TH(TH)) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .din(din),
    .rd_en(rd_en),
    .dout(dout),
    .full(full),
    .empty(empty),
    .data_count(data_count),
    .wr_ack(wr_ack),
    .wr_err(wr_err),
    .rd_ack(rd_ack),
    .rd_err(rd_err)
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
    ,
    .almost_full(almost_full),
    .almost_empty(almost_empty)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, ".dout"}, 64'(dout), 64'(m_dout));
    check({tag, ".count"}, 64'(data_count), 64'(n));
    check({tag, ".full"}, 64'(full), 64'(n == DEPTH));
    check({tag, ".empty"}, 64'(empty), 64'(n == 0));
    check({tag, ".wr_ack"}, 64'(wr_ack), 64'(m_wa));
    check({tag, ".wr_err"}, 64'(wr_err), 64'(m_we));
    check({tag, ".rd_ack"}, 64'(rd_ack), 64'(m_ra));
    check({tag, ".rd_err"}, 64'(rd_err), 64'(m_re));
`ifdef SYNC_FIFO_ALMOST_FLAGS_EN
    check({tag, ".almost_full"}, 64'(almost_full), 64'(n >= DEPTH - TH));
    check({tag, ".almost_empty"}, 64'(almost_empty), 64'(n <= TH));
`endif
  endtask
  task automatic step(input string tag, input logic w, input logic [DATA_W-1:0] d, input logic r, input logic rst);
    wr_en = w;
    din   = d;
    rd_en = r;
    reset = rst;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_dout = '0;
      {m_wa, m_we, m_ra, m_re} = '0;
    end else begin
      m_ra = r && q.size() > 0;
      m_re = r && !m_ra;
      m_wa = w && (q.size() < DEPTH || m_ra);
      m_we = w && !m_wa;
      if (m_ra) m_dout = q.pop_front();
      if (m_wa) q.push_back(d);
    end
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    reset = 1'b0;
    check_all(tag);
  endtask
  initial begin
    int pw, pr;
    step("rst", 0, '0, 0, 1);
    step("rst", 0, '0, 0, 1);
    step("idle", 0, '0, 0, 0);
    step("idle", 0, '0, 0, 0);
    check("t1.count", 64'(data_count), 64'd0);
    check("t1.empty", 64'(empty), 64'd1);
    for (int i = 0; i < DEPTH; i++) step("t2.wr", 1, 32'hA0 + i, 0, 0);
    check("t2.full", 64'(full), 64'd1);
    step("t2.ovf", 1, 32'hFF, 0, 0);
    check("t2.wr_err", 64'(wr_err), 64'd1);
    check("t2.count8", 64'(data_count), 64'd8);
    for (int i = 0; i < DEPTH; i++) begin
      step("t2.rd", 0, '0, 1, 0);
      check("t2.order", 64'(dout), 64'(32'hA0 + i));
    end
    check("t2.empty", 64'(empty), 64'd1);
    step("t3.udf", 0, '0, 1, 0);
    check("t3.rd_err", 64'(rd_err), 64'd1);
    check("t3.hold", 64'(dout), 64'h0A7);
    step("t3.both", 1, 32'h55, 1, 0);
    check("t3.wr_ack", 64'(wr_ack), 64'd1);
    check("t3.rd_err2", 64'(rd_err), 64'd1);
    check("t3.count1", 64'(data_count), 64'd1);
    for (int i = 1; i < DEPTH; i++) step("t4.fill", 1, 32'hB0 + i, 0, 0);
    step("t4.both", 1, 32'h77, 1, 0);
    check("t4.acks", 64'({wr_ack, rd_ack}), 64'b11);
    check("t4.count8", 64'(data_count), 64'd8);
    check("t4.oldest", 64'(dout), 64'h55);
    for (int i = 0; i < DEPTH - 1; i++) step("t4.rd", 0, '0, 1, 0);
    step("t4.last", 0, '0, 1, 0);
    check("t4.wrap", 64'(dout), 64'h77);
    for (int i = 0; i < 5; i++) step("t5.wr", 1, 32'hC0 + i, 0, 0);
    check("t5.count5", 64'(data_count), 64'd5);
    step("t5.rst", 1, 32'hEE, 0, 1);
    check("t5.cleared", 64'({data_count, empty, wr_ack}), 64'({4'd0, 1'b1, 1'b0}));
    step("t5.wr", 1, 32'h11, 0, 0);
    step("t5.rd", 0, '0, 1, 0);
    check("t5.data", 64'(dout), 64'h11);
    for (int i = 0; i < 3000; i++) begin
      pw = ((i / 200) % 2 == 0) ? 75 : 30;
      pr = 100 - pw;
      step("rand", $urandom_range(0, 99) < pw, $urandom, $urandom_range(0, 99) < pr,
           $urandom_range(0, 249) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO: register-file storage, one-hot gated write decode, registered read port, and occupancy tracking.
- Generalises the fixed 8-entry write-decode path to 2^ADDR_W entries of DATA_W bits.
- Adds pointer management, status flags and per-access ack/error handshakes.
- Sits between a producer and a consumer in the same clock domain; it is the team's standard buffering block.

Parameters:
- DATA_W, 32, width of each data word.
- ADDR_W, 3, pointer width; DEPTH = 2^ADDR_W entries (default 8).
- ALMOST_TH, 1, threshold in entries for almost_full/almost_empty (optional feature only); legal range 1..DEPTH-1.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- din  input  DATA_W  write data.
- rd_en  input  1  read request.
- dout  output  DATA_W  registered read data.
- full  output  1  data_count == DEPTH.
- empty  output  1  data_count == 0.
- data_count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- wr_ack  output  1  previous-cycle write accepted.
- wr_err  output  1  previous-cycle write rejected (overflow).
- rd_ack  output  1  previous-cycle read accepted; dout valid.
- rd_err  output  1  previous-cycle read rejected (underflow).

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-high, sampled on the rising edge of clk.
  - Reset takes priority over all requests in the same cycle.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, data_count = 0.
  - dout = 0; wr_ack = wr_err = rd_ack = rd_err = 0.
  - full = 0, empty = 1.
  - Storage array is not reset; its contents are don't-care.
- Reset mid-operation: any in-flight request is discarded, the FIFO is logically empty, and no ack or err is issued for the reset cycle.
- Write decode:
  - ADDR_W-to-DEPTH one-hot decode of wr_ptr, each bit ANDed with the internal write-accept signal.
  - At most one entry is written per cycle.
- Write accept:
  - Condition: wr_en=1 and (full=0 or rd accept in the same cycle).
  - Action: mem[wr_ptr] <= din; wr_ptr <= wr_ptr+1 (mod DEPTH); wr_ack=1 next cycle.
- Write reject: wr_en=1 and full with no concurrent read accept.
  - wr_err=1 next cycle.
  - No state change.
- Read accept:
  - Condition: rd_en=1 and empty=0.
  - Action: dout <= mem[rd_ptr]; rd_ptr <= rd_ptr+1 (mod DEPTH); rd_ack=1 next cycle.
  - Latency: 1 cycle from the request edge.
- Read reject: rd_en=1 and empty.
  - rd_err=1 next cycle.
  - dout holds its previous value.
- Simultaneous requests:
  - Both accepted: data_count unchanged.
  - Full with wr_en and rd_en: read accepted; write also accepted (the slot is freed the same edge); count stays DEPTH.
  - Empty with wr_en and rd_en: write accepted, read rejected (rd_err=1); count becomes 1. There is no fall-through.
- Count update: data_count += wr_accept - rd_accept.
- Flags: full and empty are combinational decodes of data_count.
- Wrap-around: pointers are ADDR_W bits and wrap DEPTH-1 -> 0 naturally.
- Ack/err timing:
  - Each of wr_ack, wr_err, rd_ack, rd_err is a single-cycle pulse, registered, cleared when no corresponding request occurs.
  - wr_ack and wr_err are never both 1; rd_ack and rd_err are never both 1.
- Idle: with no requests, all state holds and the ack/err outputs are 0.

Optional Feature:
- Macro: SYNC_FIFO_ALMOST_FLAGS_EN.
- When defined, two extra output ports are added:
  - almost_full = (data_count >= DEPTH-ALMOST_TH).
  - almost_empty = (data_count <= ALMOST_TH).
  - Both are combinational from data_count.
  - Reset values: almost_full=0, almost_empty=1.
- When undefined, these ports and their logic are absent, and ALMOST_TH is unused.

Test Plan (all with DATA_W=32, ADDR_W=3):
1. Reset then idle 2 cycles -> empty=1, full=0, data_count=0, dout=0, all ack/err=0.
2. Write 0xA0..0xA7 on 8 consecutive cycles -> wr_ack=1 for each; full=1, data_count=8. A 9th write of 0xFF -> wr_err=1, count stays 8. Then read 8 -> dout=0xA0..0xA7 in order with rd_ack=1, then empty=1.
3. Read on empty -> rd_err=1, dout holds 0xA7, rd_ptr unchanged. Simultaneous wr 0x55/rd on empty -> wr_ack=1, rd_err=1, data_count=1.
4. Full FIFO, simultaneous wr 0x77 and rd -> wr_ack=1, rd_ack=1, count=8, dout=oldest entry. 7 further reads, then 1 more read -> dout=0x77 (wrap-around verified).
5. Reset asserted mid-burst at count=5 together with wr_en=1 -> next cycle count=0, empty=1, wr_ack=0, then a write of 0x11 and a read returns 0x11.
6. With SYNC_FIFO_ALMOST_FLAGS_EN and ALMOST_TH=2 -> almost_empty=1 at counts 0..2, almost_full=1 at counts 6..8; both checked while filling 0->8 and draining 8->0.
